// File: rtl/seg7_scan_pkg.sv
// seg7_scan shared definitions: register offsets, CTRL bit positions
// and the register-select type used by the bus decoder.
package seg7_scan_pkg;

    localparam int unsigned OFF_VALUE = 32'd0;
    localparam int unsigned OFF_DP    = 32'd1;
    localparam int unsigned OFF_CTRL  = 32'd2;
    localparam int unsigned OFF_RAW0  = 32'd3;

    localparam int unsigned CTRL_ON_BIT     = 0;
    localparam int unsigned CTRL_RAW_BIT    = 1;
    localparam int unsigned CTRL_BRIGHT_LSB = 8;

    typedef enum logic [1:0] {
        REG_VALUE,
        REG_DP,
        REG_CTRL,
        REG_RAW
    } reg_sel_e;

endpackage

// File: rtl/seg7_scan_decode.sv
// Hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational so any hex display can share it.
module seg7_scan_decode (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        unique case (i_nib)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Memory-mapped N-digit seven-segment scanner: hex/raw modes, per-digit dp,
// PWM brightness and inter-digit blanking on active-low board pins.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter logic [11:0] BASE       = 12'h100,
    parameter int          DIGITS     = 4,
    parameter int          PRESCALE_W = 16,
    parameter int          BRIGHT_W   = 4,
    parameter int          BLANK      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rw,
    input  logic [31:0]       addr,
    inout  wire  [31:0]       data,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Per-digit storage is padded to a power of two so the scan index
    // can address it without range gaps; pad entries stay at reset.
    localparam int NSLOT = 1 << IDX_W;

    logic [NSLOT-1:0][3:0]  r_value;
    logic [NSLOT-1:0]       r_dp;
    logic [NSLOT-1:0][7:0]  r_rawseg;
    logic                   r_on;
    logic                   r_raw;
    logic [BRIGHT_W-1:0]    r_bright;
    logic [PRESCALE_W-1:0]  r_slot;
    logic [IDX_W-1:0]       r_idx;
    logic [7:0]             r_seg;
    logic [DIGITS-1:0]      r_an;

    logic [31:0]            w_off;
    logic [31:0]            w_rawoff;
    logic [31:0]            w_rdata;
    logic                   w_hit;
    logic                   w_wr;
    logic                   w_oe;
    reg_sel_e               w_sel;
    logic [IDX_W-1:0]       w_ridx;
    logic [6:0]             w_hex7;
    logic [7:0]             w_pat;
    logic [BRIGHT_W-1:0]    w_phase;
    logic                   w_lit;
    logic [DIGITS-1:0]      w_an;
    logic                   w_unused_data;

    assign w_off    = addr - {20'd0, BASE};
    assign w_rawoff = w_off - OFF_RAW0;
    assign w_ridx   = w_rawoff[IDX_W-1:0];

    always_comb begin
        w_hit = 1'b0;
        w_sel = REG_VALUE;
        if (addr >= {20'd0, BASE}) begin
            unique case (1'b1)
                (w_off == OFF_VALUE): begin
                    w_hit = 1'b1;
                    w_sel = REG_VALUE;
                end
                (w_off == OFF_DP): begin
                    w_hit = 1'b1;
                    w_sel = REG_DP;
                end
                (w_off == OFF_CTRL): begin
                    w_hit = 1'b1;
                    w_sel = REG_CTRL;
                end
                (w_off >= OFF_RAW0 && w_rawoff < 32'(DIGITS)): begin
                    w_hit = 1'b1;
                    w_sel = REG_RAW;
                end
                default: w_hit = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        unique case (w_sel)
            REG_VALUE: w_rdata[4*DIGITS-1:0] = r_value[DIGITS-1:0];
            REG_DP:    w_rdata[DIGITS-1:0]   = r_dp[DIGITS-1:0];
            REG_CTRL: begin
                w_rdata[CTRL_ON_BIT]                  = r_on;
                w_rdata[CTRL_RAW_BIT]                 = r_raw;
                w_rdata[CTRL_BRIGHT_LSB +: BRIGHT_W]  = r_bright;
            end
            REG_RAW:   w_rdata[7:0] = r_rawseg[w_ridx];
        endcase
    end

    assign w_wr = enable & rw & w_hit;
    assign w_oe = enable & ~rw & w_hit;
    assign data = w_oe ? w_rdata : 'z;
    assign w_unused_data = ^data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value  <= '0;
            r_dp     <= '0;
            r_rawseg <= '0;
            r_on     <= 1'b1;
            r_raw    <= 1'b0;
            r_bright <= '1;
        end else if (w_wr) begin
            unique case (w_sel)
                REG_VALUE: r_value[DIGITS-1:0] <= data[4*DIGITS-1:0];
                REG_DP:    r_dp[DIGITS-1:0]    <= data[DIGITS-1:0];
                REG_CTRL: begin
                    r_on     <= data[CTRL_ON_BIT];
                    r_raw    <= data[CTRL_RAW_BIT];
                    r_bright <= data[CTRL_BRIGHT_LSB +: BRIGHT_W];
                end
                REG_RAW:   r_rawseg[w_ridx] <= data[7:0];
            endcase
        end
    end

    // Slot counter free-runs even while dark so the scan phase survives on=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else begin
            r_slot <= r_slot + 1'b1;
            if (&r_slot) begin
                if (r_idx == IDX_W'(DIGITS - 1))
                    r_idx <= '0;
                else
                    r_idx <= r_idx + 1'b1;
            end
        end
    end

    seg7_scan_decode u_dec (
        .i_nib (r_value[r_idx]),
        .o_seg (w_hex7)
    );

    assign w_pat   = r_raw ? r_rawseg[r_idx] : {r_dp[r_idx], w_hex7};
    assign w_phase = r_slot[PRESCALE_W-1 -: BRIGHT_W];
    assign w_lit   = r_on
                   && (r_slot >= PRESCALE_W'(BLANK))
                   && (w_phase < r_bright);
    assign w_an    = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else if (w_lit) begin
            r_seg <= ~w_pat;
            r_an  <= w_an;
        end else begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: table-driven bus vectors plus
// hand-written scan, brightness, on/off and reset sequences.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] tb_wd;
    logic        tb_oe;
    wire  [31:0] data;
    wire  [31:0] unused_data1;
    wire  [31:0] unused_data8;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [7:0]  seg1;
    logic [0:0]  an1;
    logic [7:0]  seg8;
    logic [7:0]  an8;

    int checks = 0;
    int errors = 0;

    assign data = tb_oe ? tb_wd : 'z;

    always #5 clk = ~clk;

    seg7_scan #(.BASE(12'h100), .DIGITS(4), .PRESCALE_W(4),
                .BRIGHT_W(2), .BLANK(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rw(rw),
        .addr(addr), .data(data), .seg(seg), .an(an));

    seg7_scan #(.BASE(12'h100), .DIGITS(1), .PRESCALE_W(4),
                .BRIGHT_W(2), .BLANK(2)) u1 (
        .clk(clk), .reset(reset), .enable(1'b0), .rw(1'b0),
        .addr(32'h0), .data(unused_data1), .seg(seg1), .an(an1));

    seg7_scan #(.BASE(12'h100), .DIGITS(8), .PRESCALE_W(4),
                .BRIGHT_W(2), .BLANK(2)) u8 (
        .clk(clk), .reset(reset), .enable(1'b0), .rw(1'b0),
        .addr(32'h0), .data(unused_data8), .seg(seg8), .an(an8));

    typedef struct {
        logic        en;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        ck;
        logic        hz;
        logic [31:0] exp;
        string       nm;
    } bus_vec_t;

    bus_vec_t vq[$];

    logic [7:0] seen_seg[4];
    bit         seen_f[4];
    int         walk[$];
    int         lit_cnt;
    int         dark_bad;
    int         bexp[4] = '{0, 8, 24, 40};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bus_vec_t mk(input logic en, input logic wr,
                                    input logic [31:0] a, input logic [31:0] d,
                                    input logic ck, input logic hz,
                                    input logic [31:0] e, input string nm);
        bus_vec_t v;
        v.en = en; v.wr = wr; v.a = a; v.d = d;
        v.ck = ck; v.hz = hz; v.exp = e; v.nm = nm;
        return v;
    endfunction

    function automatic bus_vec_t wr(input logic [31:0] a, input logic [31:0] d);
        return mk(1'b1, 1'b1, a, d, 1'b0, 1'b0, 32'h0, "wr");
    endfunction

    function automatic bus_vec_t rd(input logic [31:0] a, input logic [31:0] e,
                                    input string nm);
        return mk(1'b1, 1'b0, a, 32'h0, 1'b1, 1'b0, e, nm);
    endfunction

    function automatic bus_vec_t rdz(input logic en, input logic [31:0] a,
                                     input string nm);
        return mk(en, 1'b0, a, 32'h0, 1'b1, 1'b1, 32'h0, nm);
    endfunction

    task automatic idle();
        enable = 1'b0; rw = 1'b0; tb_oe = 1'b0; addr = 32'h0; tb_wd = 32'h0;
    endtask

    task automatic bus_op(input bus_vec_t v);
        @(negedge clk);
        enable = v.en; rw = v.wr; addr = v.a; tb_wd = v.d; tb_oe = v.wr;
        #1;
        if (v.ck) begin
            if (v.hz) begin
                checks++;
                if (!($isunknown(data) || data == 32'h0)) begin
                    errors++;
                    $display("FAIL %s: data driven %h want hi-z", v.nm, data);
                end
            end else begin
                chk(v.nm, data, v.exp);
            end
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic run_vq();
        foreach (vq[i]) bus_op(vq[i]);
        vq.delete();
        repeat (2) @(negedge clk);
    endtask

    function automatic int anode_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic wait_an(input logic [3:0] target, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (an == target) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic observe(input int n);
        int d;
        int last;
        int bad_oh;
        last = -1;
        bad_oh = 0;
        lit_cnt = 0;
        dark_bad = 0;
        walk.delete();
        for (int k = 0; k < 4; k++) begin
            seen_f[k] = 1'b0;
            seen_seg[k] = 8'h00;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                lit_cnt++;
                d = anode_idx(an);
                if (d < 0) begin
                    bad_oh++;
                end else begin
                    if (!seen_f[d]) begin
                        seen_f[d] = 1'b1;
                        seen_seg[d] = seg;
                    end
                    if (d != last) walk.push_back(d);
                    last = d;
                end
            end else if (seg != 8'hFF) begin
                dark_bad++;
            end
        end
        chk("an_onehot", 32'(bad_oh), 32'd0);
        chk("dark_seg", 32'(dark_bad), 32'd0);
    endtask

    task automatic check_walk(input string nm);
        chk({nm, "_len"}, 32'(walk.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < walk.size(); k++)
            chk($sformatf("%s_%0d", nm, k), 32'(walk[k]), 32'(k % 4));
    endtask

    // After reset deasserts: slots 0,1 are blanked, slot 2 lights digit 0.
    task automatic post_reset(input string nm);
        @(negedge clk);
        chk({nm, "_e1_an"}, 32'(an), 32'hF);
        @(negedge clk);
        chk({nm, "_e2_an"}, 32'(an), 32'hF);
        @(negedge clk);
        chk({nm, "_e3_an"}, 32'(an), 32'hE);
        chk({nm, "_e3_seg"}, 32'(seg), 32'hC0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit prev_dark;
        int len;
        int last8;
        int first8;
        int trans8;
        int bad8;
        int lit1;
        int bad1;

        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_an8", 32'(an8), 32'hFF);
        chk("rst_an1", 32'(an1), 32'h1);

        vq.push_back(rd(32'h102, 32'h0301, "rst_ctrl"));
        vq.push_back(rd(32'h100, 32'h0, "rst_value"));
        vq.push_back(rd(32'h101, 32'h0, "rst_dp"));
        vq.push_back(rd(32'h103, 32'h0, "rst_raw0"));
        vq.push_back(rd(32'h106, 32'h0, "rst_raw3"));
        foreach (vq[i]) bus_op(vq[i]);
        vq.delete();

        @(negedge clk);
        reset = 1'b0;
        post_reset("start");

        vq.push_back(wr(32'h100, 32'hFFFF_12AF));
        vq.push_back(wr(32'h101, 32'hFFFF_FFF4));
        vq.push_back(rd(32'h100, 32'h0000_12AF, "rd_value"));
        vq.push_back(rd(32'h101, 32'h0000_0004, "rd_dp"));
        run_vq();
        wait_an(4'b1110, "hex_sync");
        observe(80);
        chk("hex_d0", 32'(seen_seg[0]), 32'h8E);
        chk("hex_d1", 32'(seen_seg[1]), 32'h88);
        chk("hex_d2_dp", 32'(seen_seg[2]), 32'h24);
        chk("hex_d3", 32'(seen_seg[3]), 32'hF9);
        check_walk("walk4");

        vq.push_back(wr(32'h102, 32'h0000_0303));
        vq.push_back(wr(32'h104, 32'h0000_0080));
        vq.push_back(rd(32'h102, 32'h0303, "rd_ctrl_raw"));
        vq.push_back(rd(32'h104, 32'h0080, "rd_raw1"));
        run_vq();
        wait_an(4'b1110, "raw_sync");
        observe(80);
        chk("raw_d1", 32'(seen_seg[1]), 32'h7F);
        chk("raw_d0", 32'(seen_seg[0]), 32'hFF);
        chk("raw_d2", 32'(seen_seg[2]), 32'hFF);
        chk("raw_d3", 32'(seen_seg[3]), 32'hFF);
        check_walk("rawwalk");

        vq.push_back(wr(32'h106, 32'h0000_015A));
        vq.push_back(wr(32'h107, 32'h0000_DEAD));
        vq.push_back(wr(32'h0FF, 32'h0000_BEEF));
        vq.push_back(mk(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, "wr_en0"));
        vq.push_back(rd(32'h106, 32'h005A, "rd_raw3"));
        vq.push_back(rd(32'h103, 32'h0, "rd_raw0_kept"));
        vq.push_back(rd(32'h100, 32'h12AF, "rd_value_kept"));
        vq.push_back(rd(32'h102, 32'h0303, "rd_ctrl_kept"));
        vq.push_back(rdz(1'b1, 32'h107, "hiz_base7"));
        vq.push_back(rdz(1'b1, 32'h0FF, "hiz_below"));
        vq.push_back(rdz(1'b0, 32'h100, "hiz_en0_value"));
        vq.push_back(rdz(1'b0, 32'h106, "hiz_en0_raw3"));
        run_vq();

        for (int b = 0; b < 4; b++) begin
            vq.push_back(wr(32'h102, 32'(b << 8) | 32'h1));
            run_vq();
            observe(64);
            chk($sformatf("bright_%0d", b), 32'(lit_cnt), 32'(bexp[b]));
        end

        found = 1'b0;
        prev_dark = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (prev_dark && an != 4'hF) found = 1'b1;
            prev_dark = (an == 4'hF);
        end
        chk("onoff_sync", 32'(found), 32'd1);
        enable = 1'b1; rw = 1'b1; addr = 32'h102; tb_wd = 32'h0300; tb_oe = 1'b1;
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("onoff_edge1_lit", 32'(an != 4'hF), 32'd1);
        @(negedge clk);
        chk("onoff_edge2_an", 32'(an), 32'hF);
        chk("onoff_edge2_seg", 32'(seg), 32'hFF);
        observe(32);
        chk("off_lit", 32'(lit_cnt), 32'd0);
        vq.push_back(wr(32'h102, 32'h0301));
        run_vq();
        found = 1'b0;
        prev_dark = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (prev_dark && an != 4'hF) found = 1'b1;
            prev_dark = (an == 4'hF);
        end
        len = 1;
        for (int i = 0; i < 20 && found; i++) begin
            @(negedge clk);
            if (an != 4'hF) len++;
            else found = 1'b0;
        end
        chk("on_runlen", 32'(len), 32'd10);

        wait_an(4'b1011, "mid_sync");
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'hFF);
        vq.push_back(rd(32'h100, 32'h0, "midrst_value"));
        vq.push_back(rd(32'h102, 32'h0301, "midrst_ctrl"));
        foreach (vq[i]) bus_op(vq[i]);
        vq.delete();
        @(negedge clk);
        reset = 1'b0;
        post_reset("restart");

        last8 = -1;
        first8 = -1;
        trans8 = 0;
        bad8 = 0;
        lit1 = 0;
        bad1 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (an8 != 8'hFF) begin
                for (int k = 0; k < 8; k++) begin
                    if (an8 == ~(8'(1) << k) && k != last8) begin
                        if (last8 >= 0 && k != (last8 + 1) % 8) bad8++;
                        if (first8 < 0) first8 = k;
                        trans8++;
                        last8 = k;
                    end
                end
                if (seg8 != 8'hC0) bad8++;
            end
            if (an1 == 1'b0) begin
                lit1++;
                if (seg1 != 8'hC0) bad1++;
            end
        end
        chk("d8_first", 32'(first8), 32'd0);
        chk("d8_walk_bad", 32'(bad8), 32'd0);
        chk("d8_trans", 32'(trans8 >= 17), 32'd1);
        chk("d1_lit", 32'(lit1), 32'd189);
        chk("d1_seg_bad", 32'(bad1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
